// File: rtl/icsp_program_loader.sv
// icsp_program_loader: serial in-circuit programming slave for a PIC16F-style core.
// Takes 6-bit commands and 16-bit data frames LSB first on PGC/PGD, drives the
// program-memory write/read strobes and holds the core in reset while programming.
module icsp_program_loader #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DEPTH       = 1024,
    parameter int PROG_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_mode,
    input  logic                  icsp_clk,
    input  logic                  icsp_data_in,
    output logic                  icsp_data_out,
    output logic                  icsp_data_oe,
    output logic                  core_hold,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic                  pm_wr_en,
    output logic [13:0]           pm_wr_data,
    output logic                  pm_rd_en,
    input  logic [13:0]           pm_rd_data,
    output logic                  busy
);
    localparam int CW = $clog2(DEPTH + PROG_CYCLES + 1);

    localparam logic [5:0] CMD_LOAD       = 6'b000010;
    localparam logic [5:0] CMD_READ       = 6'b000100;
    localparam logic [5:0] CMD_INC_ADDR   = 6'b000110;
    localparam logic [5:0] CMD_BEGIN_PROG = 6'b001000;
    localparam logic [5:0] CMD_BULK_ERASE = 6'b001001;
    localparam logic [5:0] CMD_RESET_ADDR = 6'b010110;

    typedef enum logic [2:0] {
        IDLE, CMD, DATA_IN, READ_FETCH, DATA_OUT, PROG, ERASE
    } state_t;

    state_t                state, state_next;
    logic [1:0]            pgc_sync, pgd_sync;
    logic                  pgc_prev, pgc_rise, pgc_fall, pgd;
    logic [4:0]            bit_cnt;
    logic [CW-1:0]         work_cnt;
    logic [13:0]           shift_reg;
    logic [15:0]           out_shift;
    logic                  out_bit;
    logic [13:0]           latch;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [5:0]            cmd_word;
    logic                  cmd_done, frame_done, erase_writing, restart;

    assign pgd           = pgd_sync[1];
    assign pgc_rise      = pgc_sync[1] & ~pgc_prev;
    assign pgc_fall      = ~pgc_sync[1] & pgc_prev;
    // The five earlier command bits sit at the top of the shifter; the sixth is on PGD now.
    assign cmd_word      = {pgd, shift_reg[13:9]};
    assign cmd_done      = (state == CMD) && pgc_fall && (bit_cnt == 5'd5);
    assign frame_done    = pgc_fall && (bit_cnt == 5'd15);
    assign erase_writing = (state == ERASE) && (work_cnt < CW'(DEPTH));
    // Counters restart on every state change and after each decoded command.
    assign restart       = (state_next != state) || cmd_done;

    // Synchronise the PGC/PGD pins and register prog_mode into core_hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pgc_sync  <= 2'b00;
            pgd_sync  <= 2'b00;
            pgc_prev  <= 1'b0;
            core_hold <= 1'b0;
        end else begin
            pgc_sync  <= {pgc_sync[0], icsp_clk};
            pgd_sync  <= {pgd_sync[0], icsp_data_in};
            pgc_prev  <= pgc_sync[1];
            core_hold <= prog_mode;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic; dropping prog_mode aborts whatever is in flight.
    always_comb begin
        state_next = state;
        if (!prog_mode) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       state_next = CMD;
                CMD: begin
                    if (cmd_done) begin
                        case (cmd_word)
                            CMD_LOAD:       state_next = DATA_IN;
                            CMD_READ:       state_next = READ_FETCH;
                            CMD_BEGIN_PROG: state_next = PROG;
                            CMD_BULK_ERASE: state_next = ERASE;
                            default:        state_next = CMD;
                        endcase
                    end
                end
                DATA_IN:    if (frame_done) state_next = CMD;
                READ_FETCH: if (work_cnt == CW'(1)) state_next = DATA_OUT;
                DATA_OUT:   if (frame_done) state_next = CMD;
                PROG:       if (work_cnt == CW'(PROG_CYCLES - 1)) state_next = CMD;
                ERASE:      if (work_cnt == CW'(DEPTH + PROG_CYCLES - 1)) state_next = CMD;
                default:    state_next = IDLE;
            endcase
        end
    end

    // Datapath: bit/work counters, shifters, data latch and address counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            work_cnt  <= '0;
            shift_reg <= '0;
            out_shift <= '0;
            out_bit   <= 1'b0;
            latch     <= 14'h3FFF;
            addr_cnt  <= '0;
        end else begin
            if (restart) begin
                bit_cnt  <= '0;
                work_cnt <= '0;
            end else begin
                if (pgc_fall && (state == CMD || state == DATA_IN || state == DATA_OUT))
                    bit_cnt <= bit_cnt + 5'd1;
                if (state == READ_FETCH || state == PROG || state == ERASE)
                    work_cnt <= work_cnt + CW'(1);
            end

            if (pgc_fall && (state == CMD || state == DATA_IN))
                shift_reg <= {pgd, shift_reg[13:1]};

            if (state == READ_FETCH && work_cnt == CW'(1)) begin
                out_shift <= {1'b0, pm_rd_data, 1'b0};
                out_bit   <= 1'b0;
            end else if (state == DATA_OUT && pgc_rise) begin
                out_bit   <= out_shift[0];
                out_shift <= {1'b0, out_shift[15:1]};
            end else if (state != DATA_OUT) begin
                out_bit   <= 1'b0;
            end

            // At the 16th fall the shifter holds exactly frame bits 1..14.
            if (prog_mode && state == DATA_IN && frame_done)
                latch <= shift_reg;
            else if (state == ERASE && state_next == CMD)
                latch <= 14'h3FFF;

            if (!prog_mode)
                addr_cnt <= '0;
            else if (cmd_done && cmd_word == CMD_INC_ADDR)
                addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            else if (cmd_done && cmd_word == CMD_RESET_ADDR)
                addr_cnt <= '0;
        end
    end

    // Outputs decoded from the current state; erase borrows pm_addr for its own sweep.
    always_comb begin
        icsp_data_oe  = (state == DATA_OUT);
        icsp_data_out = (state == DATA_OUT) & out_bit;
        pm_rd_en      = (state == READ_FETCH) && (work_cnt == '0);
        pm_wr_en      = ((state == PROG) && (work_cnt == '0)) || erase_writing;
        pm_wr_data    = 14'h0000;
        if (pm_wr_en)
            pm_wr_data = (state == ERASE) ? 14'h3FFF : latch;
        busy          = (state == PROG) || (state == ERASE);
        pm_addr       = erase_writing ? ADDR_WIDTH'(work_cnt) : addr_cnt;
    end
endmodule
